// File: rtl/stb_req_master.sv
`default_nettype none
// ============================================================================
// stb_req_master: requests strobes and samples a synced comparator per strobe
// Revision: 1.0
// ============================================================================
module stb_req_master #(
  parameter int CNT_WIDTH   = 16,
  parameter int TO_WIDTH    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_WIDTH-1:0] num_samples_i,
  input  logic [TO_WIDTH-1:0]  timeout_i,
  input  logic                 rdy_i,
  input  logic                 stb_valid_i,
  input  logic                 cmp_i,
  output logic                 stb_req_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] sample_cnt_o,
  output logic [CNT_WIDTH-1:0] hit_cnt_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    REQ      = 3'd2,
    WAIT_VLO = 3'd3,
    WAIT_VHI = 3'd4,
    SAMPLE   = 3'd5,
    FINISH   = 3'd6
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 cmp_sync;
  logic [TO_WIDTH-1:0]  to_cnt_q;
  logic [CNT_WIDTH-1:0] sample_cnt_q;
  logic [CNT_WIDTH-1:0] hit_cnt_q;
  logic                 err_q;
  logic                 start_run;
  logic                 take_sample;
  logic                 set_err;
  logic                 timed_out;
  logic                 in_wait;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= cmp_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign cmp_sync  = sync_q[SYNC_STAGES-1];
  assign in_wait   = (state_q == WAIT_RDY) || (state_q == WAIT_VLO) || (state_q == WAIT_VHI);
  // Each wait state may last at most timeout_i cycles.
  assign timed_out = (timeout_i != '0) && ((to_cnt_q + TO_WIDTH'(1)) == timeout_i);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_run   = 1'b0;
    take_sample = 1'b0;
    set_err     = 1'b0;
    stb_req_o   = (state_q == REQ);
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == FINISH);
    if (abort_i && (state_q != IDLE) && (state_q != FINISH)) begin
      state_d = FINISH;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            start_run = 1'b1;
            state_d   = (num_samples_i == '0) ? FINISH : WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (rdy_i) begin
            state_d = REQ;
          end else if (timed_out) begin
            set_err = 1'b1;
            state_d = FINISH;
          end
        end
        REQ: state_d = WAIT_VLO;
        WAIT_VLO: begin
          if (!stb_valid_i) begin
            state_d = WAIT_VHI;
          end else if (timed_out) begin
            set_err = 1'b1;
            state_d = FINISH;
          end
        end
        WAIT_VHI: begin
          if (stb_valid_i) begin
            state_d = SAMPLE;
          end else if (timed_out) begin
            set_err = 1'b1;
            state_d = FINISH;
          end
        end
        SAMPLE: begin
          take_sample = 1'b1;
          state_d     = ((sample_cnt_q + CNT_WIDTH'(1)) == num_samples_i) ? FINISH : REQ;
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sample_cnt_q <= '0;
      hit_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else if (start_run) begin
      sample_cnt_q <= '0;
      hit_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      if (take_sample) begin
        sample_cnt_q <= sample_cnt_q + CNT_WIDTH'(1);
        if (cmp_sync) begin
          hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
        end
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  // Any state change restarts the wait budget, so each wait state starts from 0.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      to_cnt_q <= '0;
    end else if (state_d != state_q) begin
      to_cnt_q <= '0;
    end else if (in_wait) begin
      to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
    end
  end

  assign err_o        = err_q;
  assign sample_cnt_o = sample_cnt_q;
  assign hit_cnt_o    = hit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stb_req_master.sv
`default_nettype none
// tb_stb_req_master: directed and randomized runs against a transaction-level
// model of the strobe generator and expected run results.
module tb_stb_req_master;
  localparam int CNT_WIDTH   = 16;
  localparam int TO_WIDTH    = 32;
  localparam int SYNC_STAGES = 2;

  logic                 clk         = 1'b0;
  logic                 arstn       = 1'b0;
  logic                 start       = 1'b0;
  logic                 abort       = 1'b0;
  logic                 rdy         = 1'b1;
  logic                 stb_valid;
  logic                 cmp;
  logic [CNT_WIDTH-1:0] num_samples = '0;
  logic [TO_WIDTH-1:0]  timeout     = '0;
  logic                 stb_req;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [CNT_WIDTH-1:0] sample_cnt;
  logic [CNT_WIDTH-1:0] hit_cnt;

  int checks     = 0;
  int errors     = 0;
  int req_total  = 0;
  int done_total = 0;
  int gen_idx    = 0;
  int plan_base  = 0;
  bit gen_en     = 1'b1;
  bit gen_hold   = 1'b0;
  bit gen_fixed  = 1'b0;
  int gen_hi_dly = 10;
  bit cmp_plan [256];

  stb_req_master #(
    .CNT_WIDTH   (CNT_WIDTH),
    .TO_WIDTH    (TO_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_i         (clk),
    .arstn_i       (arstn),
    .start_i       (start),
    .abort_i       (abort),
    .num_samples_i (num_samples),
    .timeout_i     (timeout),
    .rdy_i         (rdy),
    .stb_valid_i   (stb_valid),
    .cmp_i         (cmp),
    .stb_req_o     (stb_req),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .sample_cnt_o  (sample_cnt),
    .hit_cnt_o     (hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse counters seen by the outside world.
  initial begin
    forever begin
      @(negedge clk);
      if (stb_req) req_total++;
      if (done) done_total++;
    end
  end

  // Strobe generator: per request, drop valid (possibly late), present the
  // planned comparator level, then raise valid after it has settled.
  initial begin
    stb_valid = 1'b0;
    cmp       = 1'b0;
    forever begin
      @(negedge clk);
      if (!gen_en) begin
        stb_valid = gen_hold;
      end else if (stb_req) begin
        repeat (gen_fixed ? 0 : $urandom_range(0, 3)) @(negedge clk);
        stb_valid = 1'b0;
        cmp       = cmp_plan[(gen_idx - plan_base) & 255];
        gen_idx++;
        repeat (gen_fixed ? gen_hi_dly : $urandom_range(SYNC_STAGES + 2, 12)) @(negedge clk);
        stb_valid = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_run(input int num, input int to, input bit poke_start,
                        output int cycles, output int first_cnt);
    num_samples = CNT_WIDTH'(num);
    timeout     = TO_WIDTH'(to);
    plan_base   = gen_idx;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cycles    = 1;
    first_cnt = int'(sample_cnt);
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (poke_start) start = (cycles == 4);
    end
    start = 1'b0;
    if (!done) check("done_seen", 0, 1);
  endtask

  task automatic wait_reqs(input int k, output int seen);
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < k && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (stb_req) seen++;
    end
  endtask

  initial begin
    int cyc;
    int first;
    int rb;
    int db;
    int n;
    int exp_hits;
    int seen;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_req", stb_req, 0);
    check("rst_samples", sample_cnt, 0);
    check("rst_hits", hit_cnt, 0);
    arstn = 1'b1;
    repeat (2) @(negedge clk);

    // Four strobes, valid 10 cycles after each request, hits on samples 2 and 4.
    gen_fixed  = 1'b1;
    gen_hi_dly = 10;
    cmp_plan[0] = 1'b0; cmp_plan[1] = 1'b1; cmp_plan[2] = 1'b0; cmp_plan[3] = 1'b1;
    rb = req_total; db = done_total;
    do_run(4, 0, 1'b0, cyc, first);
    repeat (3) @(negedge clk);
    check("dir_reqs", req_total - rb, 4);
    check("dir_done", done_total - db, 1);
    check("dir_samples", sample_cnt, 4);
    check("dir_hits", hit_cnt, 2);
    check("dir_err", err, 0);
    check("dir_busy", busy, 0);

    // Random runs with stale valids, random latencies and a stray start mid-run.
    gen_fixed = 1'b0;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      exp_hits = 0;
      for (int k = 0; k < n; k++) begin
        cmp_plan[k] = 1'($urandom_range(0, 1));
        exp_hits += int'(cmp_plan[k]);
      end
      rb = req_total; db = done_total;
      do_run(n, ($urandom_range(0, 1) != 0) ? 1000 : 0, 1'b1, cyc, first);
      repeat (4) @(negedge clk);
      check("rnd_reqs", req_total - rb, n);
      check("rnd_done", done_total - db, 1);
      check("rnd_samples", sample_cnt, n);
      check("rnd_hits", hit_cnt, exp_hits);
      check("rnd_err", err, 0);
    end

    // Zero samples: immediate finish, counts cleared, no request.
    rb = req_total; db = done_total;
    do_run(0, 0, 1'b0, cyc, first);
    repeat (2) @(negedge clk);
    check("zero_latency_ok", (cyc <= 2) ? 1 : 0, 1);
    check("zero_reqs", req_total - rb, 0);
    check("zero_done", done_total - db, 1);
    check("zero_samples", sample_cnt, 0);
    check("zero_hits", hit_cnt, 0);

    // Generator never ready: timeout of 50 cycles.
    rdy = 1'b0;
    rb = req_total; db = done_total;
    do_run(4, 50, 1'b0, cyc, first);
    repeat (2) @(negedge clk);
    rdy = 1'b1;
    check("rdy_to_window", (cyc >= 50 && cyc <= 52) ? 1 : 0, 1);
    check("rdy_to_err", err, 1);
    check("rdy_to_reqs", req_total - rb, 0);
    check("rdy_to_done", done_total - db, 1);

    // Valid never drops: stuck waiting for low, times out after 20 cycles.
    gen_en   = 1'b0;
    gen_hold = 1'b1;
    repeat (2) @(negedge clk);
    rb = req_total;
    do_run(4, 20, 1'b0, cyc, first);
    repeat (2) @(negedge clk);
    check("vhi_err", err, 1);
    check("vhi_samples", sample_cnt, 0);
    check("vhi_reqs", req_total - rb, 1);
    gen_hold = 1'b0;
    gen_en   = 1'b1;
    repeat (3) @(negedge clk);

    // Abort while waiting for valid on the third of eight strobes.
    gen_fixed  = 1'b1;
    gen_hi_dly = 20;
    exp_hits = 0;
    for (int k = 0; k < 8; k++) begin
      cmp_plan[k] = 1'($urandom_range(0, 1));
      if (k < 2) exp_hits += int'(cmp_plan[k]);
    end
    num_samples = CNT_WIDTH'(8);
    timeout     = '0;
    plan_base   = gen_idx;
    db = done_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_reqs(3, seen);
    check("abort_reach", seen, 3);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_done_pulse", done, 1);
    repeat (3) @(negedge clk);
    check("abort_samples", sample_cnt, 2);
    check("abort_hits", hit_cnt, exp_hits);
    check("abort_err", err, 0);
    check("abort_busy", busy, 0);
    check("abort_done_cnt", done_total - db, 1);
    repeat (25) @(negedge clk);
    cmp_plan[0] = 1'b1;
    do_run(1, 0, 1'b0, cyc, first);
    check("restart_clear", first, 0);
    repeat (2) @(negedge clk);
    check("restart_samples", sample_cnt, 1);
    check("restart_hits", hit_cnt, 1);

    // Asynchronous reset while waiting for valid on the third strobe.
    for (int k = 0; k < 4; k++) cmp_plan[k] = 1'b1;
    num_samples = CNT_WIDTH'(4);
    plan_base   = gen_idx;
    db = done_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_reqs(3, seen);
    check("rst_reach", seen, 3);
    repeat (4) @(negedge clk);
    check("pre_rst_samples", sample_cnt, 2);
    #2 arstn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_req", stb_req, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_samples", sample_cnt, 0);
    check("arst_hits", hit_cnt, 0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    check("arst_no_done", done_total - db, 0);
    repeat (25) @(negedge clk);
    cmp_plan[0] = 1'b0;
    rb = req_total; db = done_total;
    do_run(1, 0, 1'b0, cyc, first);
    repeat (2) @(negedge clk);
    check("post_rst_reqs", req_total - rb, 1);
    check("post_rst_done", done_total - db, 1);
    check("post_rst_samples", sample_cnt, 1);
    check("post_rst_hits", hit_cnt, 0);
    check("post_rst_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stb_req_master.md
STB_REQ_MASTER -- requirements
Module: stb_req_master

Interface
REQ-001 Parameter: CNT_WIDTH, default 16, width of sample-count and hit-count fields.
REQ-002 Parameter: TO_WIDTH, default 32, width of the per-strobe timeout counter.
REQ-003 Parameter: SYNC_STAGES, default 2, synchronizer depth for cmp_i.
REQ-004 clk_i  input  1  system clock; all logic on posedge clk_i.
REQ-005 arstn_i  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  run request, sampled in IDLE only.
REQ-007 abort_i  input  1  synchronous abort of a run in progress.
REQ-008 num_samples_i  input  CNT_WIDTH  number of strobes to request per run, held stable while busy_o=1.
REQ-009 timeout_i  input  TO_WIDTH  max cycles per wait state; 0 disables timeout.
REQ-010 rdy_i  input  1  strobe generator locked, period known.
REQ-011 stb_valid_i  input  1  strobe generator reports requested strobe active.
REQ-012 cmp_i  input  1  asynchronous comparator output to be sampled.
REQ-013 stb_req_o  output  1  strobe request to generator, posedge-triggered at the generator.
REQ-014 busy_o  output  1  run in progress.
REQ-015 done_o  output  1  one-cycle pulse at run completion, including error or abort.
REQ-016 err_o  output  1  last run ended by timeout, held until next start.
REQ-017 sample_cnt_o  output  CNT_WIDTH  strobes completed in current/last run.
REQ-018 hit_cnt_o  output  CNT_WIDTH  samples with synced cmp=1 in current/last run.

Function
REQ-019 cmp_i passes through a SYNC_STAGES flop synchronizer; only the synced value is sampled.
REQ-020 FSM states: IDLE, WAIT_RDY, REQ, WAIT_VLO, WAIT_VHI, SAMPLE, FINISH.
REQ-021 IDLE: start_i=1 -> WAIT_RDY; sample_cnt_o, hit_cnt_o, err_o cleared on that edge; busy_o=1 from next cycle.
REQ-022 IDLE with start_i=1 and num_samples_i=0 -> FINISH directly; counts stay 0, no stb_req_o pulse.
REQ-023 start_i outside IDLE is ignored.
REQ-024 WAIT_RDY: rdy_i=1 -> REQ.
REQ-025 REQ: stb_req_o=1 for exactly one cycle, then -> WAIT_VLO; stb_req_o=0 in all other states.
REQ-026 WAIT_VLO: stb_valid_i=0 -> WAIT_VHI; a stale valid from the previous strobe is never accepted.
REQ-027 WAIT_VHI: stb_valid_i=1 -> SAMPLE.
REQ-028 SAMPLE, one cycle: sample_cnt_o+1; hit_cnt_o+1 if synced cmp=1; if the incremented sample count equals num_samples_i -> FINISH, else -> REQ.
REQ-029 FINISH, one cycle: done_o=1, -> IDLE; busy_o=0 from the cycle after FINISH.
REQ-030 Timeout counter clears on entry to WAIT_RDY, WAIT_VLO and WAIT_VHI and increments each cycle in those states; when it reaches timeout_i (non-zero): err_o=1 -> FINISH.
REQ-031 abort_i=1 in any non-IDLE state -> FINISH; err_o unchanged, counts frozen; abort_i has priority over every other transition.
REQ-032 Counters do not wrap: num_samples_i bounds sample_cnt_o; hit_cnt_o <= sample_cnt_o always.
REQ-033 sample_cnt_o, hit_cnt_o and err_o hold their values in IDLE until the next accepted start.

Reset
REQ-034 arstn_i=0 -> state IDLE, stb_req_o=0, busy_o=0, done_o=0, err_o=0, counts 0, synchronizer and timeout counter 0, asynchronously.
REQ-035 Reset mid-run aborts with no done_o pulse; first start after release behaves as a fresh run.

Verification
REQ-036 num_samples=4, rdy=1, generator model raises valid 10 cycles after each req, cmp=1 on samples 2 and 4 -> 4 req pulses, done_o once, sample_cnt=4, hit_cnt=2, err=0.
REQ-037 num_samples=0 -> done_o pulse within 2 cycles of start, no stb_req_o, counts 0.
REQ-038 rdy_i held 0, timeout=50 -> err_o=1 and done_o 50..52 cycles after start, no stb_req_o.
REQ-039 valid held 1 throughout (never drops), timeout=20 -> stuck in WAIT_VLO, err_o=1, sample_cnt=0.
REQ-040 abort_i in WAIT_VHI during sample 3 of 8 -> done_o pulse, sample_cnt=2, err=0; subsequent start clears counts.
REQ-041 arstn_i asserted in WAIT_VHI -> all outputs 0 immediately; restart with num_samples=1 completes normally.
